conv_seq: RTL and testbench
===========================

# conv_seq

Sequencer and weight store that drives the 2x2 convolution MAC datapath. It accepts a stream of pixel pairs (A, B) over a valid/ready handshake and issues them to the MAC with the correct tap select. It accumulates the four per-tap MAC results into one window sum and presents it on a valid/ready result port. It also owns the eight signed 8-bit weight registers, written through a simple register-write port, and feeds them to the MAC.

## Interface
- DATA_W, 13: signed pixel width (A, B).
- W_W, 8: signed weight width.
- MAC_W, 22: width of the MAC result returned on conv_acc.
- SUM_W, 24: window sum width; must equal MAC_W + 2.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- w_we  in  1  weight write strobe.
- w_addr  in  3  0-3 select WA0-WA3; 4-7 select WB0-WB3.
- w_data  in  W_W  signed weight value.
- in_valid  in  1  pixel pair valid.
- in_ready  out  1  pixel pair accepted when in_valid && in_ready.
- in_a, in_b  in  DATA_W  signed pixels.
- conv_a, conv_b  out  DATA_W  registered operands to the MAC.
- conv_sel  out  2  registered tap index to the MAC.
- wa0..wa3, wb0..wb3  out  W_W  weight register contents.
- conv_acc  in  MAC_W  signed combinational MAC result for the current conv_a/conv_b/conv_sel.
- res_valid  out  1  window result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  SUM_W  signed window sum.

## Operation
- Weight store: when w_we is high, the register at w_addr gets w_data at the edge. A write takes effect the next cycle. An op in flight samples conv_acc before that edge, so it uses the pre-write value.
- Tap counter `tap` (2 bits) counts accepted pairs within a window.
- On accept:
  - conv_a <= in_a, conv_b <= in_b, conv_sel <= tap.
  - op_v <= 1, tap <= tap + 1 (wraps 3 -> 0).
- Without an accept, op_v <= 0. conv_a, conv_b and conv_sel hold their values.
- Accumulate cycle (op_v = 1):
  - ext = conv_acc sign-extended to SUM_W.
  - sum <= (conv_sel == 0) ? ext : sum + ext.
- Finalise: if op_v && conv_sel == 3, then res_data <= sum + ext (after the optional ReLU) and res_valid <= 1.
- Arithmetic: four MAC_W terms always fit in SUM_W. No saturation and no overflow handling.
- Result handshake: res_valid clears on res_valid && res_ready unless a new finalise happens at the same edge. In that case res_valid stays 1 and res_data takes the new value.
- Backpressure: in_ready = !(tap == 3 && res_valid && !res_ready).
  - Taps 0-2 of the next window can be accepted while a result is pending.
  - Only the closing tap stalls.
- Reset: tap = 0, op_v = 0, sum = 0, conv_a = conv_b = 0, conv_sel = 0, all weights = 0, res_valid = 0, res_data = 0.
- Reset mid-window discards the partial sum and any pending result.
- in_ready is 1 the cycle after reset.

## Timing
- Operand latency: conv_a/conv_b/conv_sel update at the accept edge.
- Result latency: res_valid rises at the edge one cycle after the tap-3 accept edge.
- Sustained throughput: one pair per cycle, i.e. one result every 4 cycles, when res_ready is held high.
- A pending result holds res_data stable until it is consumed.
- conv_acc is sampled only in cycles where op_v = 1.

## Configuration
- CONV_RELU_EN defined: the finalised value is clamped, so res_data = 0 when the full sum is negative, else the sum.
- CONV_RELU_EN not defined: res_data is the raw signed sum.
- The accumulator itself is never clamped.

## Test plan
- Basic window:
  - Stimulus: weights WA = {1,2,3,4}, WB = {-1,0,1,2}; pairs (10,5), (20,6), (30,7), (40,8) on consecutive cycles with res_ready = 1.
  - Required: conv_sel sequence 0,1,2,3; res_data = 318; res_valid high one cycle after the 4th accept.
- Width extremes:
  - Stimulus: all weights 127; all pixels 4095.
  - Required: res_data = 4160520, with no wrap.
- Backpressure:
  - Stimulus: res_ready = 0 after window 1 completes; stream window 2.
  - Required: taps 0-2 accepted; in_ready = 0 at tap 3 until res_ready rises.
  - Required: window-1 value is held; window-2 result appears one cycle after its tap-3 accept.
- ReLU:
  - Stimulus: negate all weights from the basic window.
  - Required: res_data = 0 with CONV_RELU_EN defined; -318 without it.
- Mid-window reset and weight write:
  - Stimulus: rst after 2 taps.
  - Required: tap restarts at 0; weights read 0; no res_valid.
  - Stimulus: w_we to WA0 in the same cycle as the tap-0 accept.
  - Required: that tap uses the new weight, because the write lands at the same edge as the operand register update and the op evaluates the cycle after.

Source files
------------

// File: rtl/conv_seq.sv
// -----------------------------------------------------------------------------
// conv_seq - sequencer and weight store for the 2x2 convolution MAC datapath.
//
// Accepts (A, B) pixel pairs over a valid/ready handshake and issues each pair
// to an external combinational MAC, together with the tap index (0..3) of that
// pair within the current window. The four per-tap MAC results are summed into
// one window value, which is presented on a valid/ready result port. The block
// also holds the eight signed weights (WA0-WA3, WB0-WB3) consumed by the MAC.
//
// Optional feature macro:
//   CONV_RELU_EN - when defined, a negative window sum is presented as zero.
//                  The internal accumulator is never clamped.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   w_we/w_addr/w_data  weight write port (addr 0-3 -> WA0-3, 4-7 -> WB0-3)
//   in_valid/in_ready   pixel pair handshake, in_a/in_b signed pixels
//   conv_a/conv_b       registered operands to the MAC
//   conv_sel            registered tap index to the MAC
//   wa0..wa3, wb0..wb3  weight register contents to the MAC
//   conv_acc            MAC result for the current conv_a/conv_b/conv_sel
//   res_valid/res_ready result handshake, res_data signed window sum
// -----------------------------------------------------------------------------
module conv_seq #(
    parameter int DATA_W = 13,
    parameter int W_W    = 8,
    parameter int MAC_W  = 22,
    parameter int SUM_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_we,
    input  logic        [2:0]        w_addr,
    input  logic signed [W_W-1:0]    w_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    output logic signed [DATA_W-1:0] conv_a,
    output logic signed [DATA_W-1:0] conv_b,
    output logic        [1:0]        conv_sel,
    output logic signed [W_W-1:0]    wa0,
    output logic signed [W_W-1:0]    wa1,
    output logic signed [W_W-1:0]    wa2,
    output logic signed [W_W-1:0]    wa3,
    output logic signed [W_W-1:0]    wb0,
    output logic signed [W_W-1:0]    wb1,
    output logic signed [W_W-1:0]    wb2,
    output logic signed [W_W-1:0]    wb3,
    input  logic signed [MAC_W-1:0]  conv_acc,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [SUM_W-1:0]  res_data
);

    // Clamp applied only to the value leaving the block, never to the accumulator.
    function automatic logic signed [SUM_W-1:0] relu_out(input logic signed [SUM_W-1:0] v);
`ifdef CONV_RELU_EN
        if (v[SUM_W-1]) begin
            return {SUM_W{1'b0}};
        end else begin
            return v;
        end
`else
        return v;
`endif
    endfunction

    logic signed [W_W-1:0]    wa_q [4];
    logic signed [W_W-1:0]    wa_d [4];
    logic signed [W_W-1:0]    wb_q [4];
    logic signed [W_W-1:0]    wb_d [4];
    logic        [1:0]        tap_q, tap_d;
    logic                     op_v_q, op_v_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic signed [DATA_W-1:0] conv_a_q, conv_a_d;
    logic signed [DATA_W-1:0] conv_b_q, conv_b_d;
    logic        [1:0]        conv_sel_q, conv_sel_d;
    logic                     res_valid_q, res_valid_d;
    logic signed [SUM_W-1:0]  res_data_q, res_data_d;

    logic                     in_ready_s;
    logic                     accept_s;
    logic signed [SUM_W-1:0]  ext_s;
    logic signed [SUM_W-1:0]  sum_plus_s;
    logic                     final_s;

    // Handshake and accumulate helpers; only the closing tap stalls on a pending result.
    always_comb begin
        in_ready_s = 1'b1;
        if ((tap_q == 2'd3) && res_valid_q && !res_ready) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = 1'b1;
        end
        accept_s   = in_valid && in_ready_s;
        ext_s      = {{(SUM_W-MAC_W){conv_acc[MAC_W-1]}}, conv_acc};
        sum_plus_s = sum_q + ext_s;
        final_s    = op_v_q && (conv_sel_q == 2'd3);
    end

    // Next-state logic for weights, operand issue, accumulation and result port.
    always_comb begin
        wa_d        = wa_q;
        wb_d        = wb_q;
        tap_d       = tap_q;
        op_v_d      = 1'b0;
        sum_d       = sum_q;
        conv_a_d    = conv_a_q;
        conv_b_d    = conv_b_q;
        conv_sel_d  = conv_sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        if (w_we) begin
            case (w_addr)
                3'd0:    wa_d[0] = w_data;
                3'd1:    wa_d[1] = w_data;
                3'd2:    wa_d[2] = w_data;
                3'd3:    wa_d[3] = w_data;
                3'd4:    wb_d[0] = w_data;
                3'd5:    wb_d[1] = w_data;
                3'd6:    wb_d[2] = w_data;
                3'd7:    wb_d[3] = w_data;
                default: wa_d[0] = wa_q[0];
            endcase
        end else begin
            wa_d = wa_q;
        end

        if (accept_s) begin
            conv_a_d   = in_a;
            conv_b_d   = in_b;
            conv_sel_d = tap_q;
            op_v_d     = 1'b1;
            tap_d      = tap_q + 2'd1;
        end else begin
            op_v_d = 1'b0;
        end

        // Tap 0 restarts the window sum; later taps add onto it.
        if (op_v_q) begin
            if (conv_sel_q == 2'd0) begin
                sum_d = ext_s;
            end else begin
                sum_d = sum_plus_s;
            end
        end else begin
            sum_d = sum_q;
        end

        // A finalise at the same edge as a consume wins and keeps res_valid high.
        if (final_s) begin
            res_valid_d = 1'b1;
            res_data_d  = relu_out(sum_plus_s);
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                wa_q[i] <= {W_W{1'b0}};
                wb_q[i] <= {W_W{1'b0}};
            end
            tap_q       <= 2'd0;
            op_v_q      <= 1'b0;
            sum_q       <= {SUM_W{1'b0}};
            conv_a_q    <= {DATA_W{1'b0}};
            conv_b_q    <= {DATA_W{1'b0}};
            conv_sel_q  <= 2'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= {SUM_W{1'b0}};
        end else begin
            wa_q        <= wa_d;
            wb_q        <= wb_d;
            tap_q       <= tap_d;
            op_v_q      <= op_v_d;
            sum_q       <= sum_d;
            conv_a_q    <= conv_a_d;
            conv_b_q    <= conv_b_d;
            conv_sel_q  <= conv_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign conv_a    = conv_a_q;
    assign conv_b    = conv_b_q;
    assign conv_sel  = conv_sel_q;
    assign wa0       = wa_q[0];
    assign wa1       = wa_q[1];
    assign wa2       = wa_q[2];
    assign wa3       = wa_q[3];
    assign wb0       = wb_q[0];
    assign wb1       = wb_q[1];
    assign wb2       = wb_q[2];
    assign wb3       = wb_q[3];
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_conv_seq.sv
// -----------------------------------------------------------------------------
// tb_conv_seq - directed self-checking bench for conv_seq.
// Contains a small behavioural model of the MAC (A*WA[sel] + B*WB[sel]) that
// closes the loop through conv_acc. Expected window sums are hand computed.
// -----------------------------------------------------------------------------
module tb_conv_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               w_we;
    logic        [2:0]  w_addr;
    logic signed [7:0]  w_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [12:0] in_a, in_b;
    logic signed [12:0] conv_a, conv_b;
    logic        [1:0]  conv_sel;
    logic signed [7:0]  wa0, wa1, wa2, wa3, wb0, wb1, wb2, wb3;
    logic signed [21:0] conv_acc;
    logic               res_valid;
    logic               res_ready;
    logic signed [23:0] res_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_seq dut (
        .clk(clk), .rst(rst),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .conv_a(conv_a), .conv_b(conv_b), .conv_sel(conv_sel),
        .wa0(wa0), .wa1(wa1), .wa2(wa2), .wa3(wa3),
        .wb0(wb0), .wb1(wb1), .wb2(wb2), .wb3(wb3),
        .conv_acc(conv_acc),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    // MAC model: selected weights times the registered operands.
    logic signed [7:0] wsa, wsb;
    int prod;
    always_comb begin
        case (conv_sel)
            2'd0:    begin wsa = wa0; wsb = wb0; end
            2'd1:    begin wsa = wa1; wsb = wb1; end
            2'd2:    begin wsa = wa2; wsb = wb2; end
            default: begin wsa = wa3; wsb = wb3; end
        endcase
        prod = int'(conv_a) * int'(wsa) + int'(conv_b) * int'(wsb);
    end
    assign conv_acc = prod[21:0];

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_w(input int w[8]);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            w_we   = 1'b1;
            w_addr = 3'(i);
            w_data = w[i][7:0];
        end
        @(negedge clk);
        w_we = 1'b0;
    endtask

    // Streams one window on consecutive cycles. Optionally writes WA0 in the
    // same cycle as the tap-0 accept, and optionally checks the result.
    task automatic run_window(input string tag, input int a[4], input int b[4],
                              input bit wr0, input int wr0_val,
                              input bit chk_res, input int exp_sum);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 13'(a[i]);
            in_b     = 13'(b[i]);
            if (i == 0 && wr0) begin
                w_we   = 1'b1;
                w_addr = 3'd0;
                w_data = wr0_val[7:0];
            end
            check_eq({tag, " in_ready"}, in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            w_we     = 1'b0;
            check_eq({tag, " conv_sel"}, conv_sel, i);
            check_eq({tag, " conv_a"}, conv_a, a[i]);
        end
        if (chk_res) begin
            check_eq({tag, " res_valid early"}, res_valid, 0);
            @(posedge clk);
            #1;
            check_eq({tag, " res_valid"}, res_valid, 1);
            check_eq({tag, " res_data"}, res_data, exp_sum);
            if (res_ready) begin
                @(posedge clk);
                #1;
                check_eq({tag, " res_valid clear"}, res_valid, 0);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        w_we      = 1'b0;
        w_addr    = 3'd0;
        w_data    = 8'sd0;
        in_valid  = 1'b0;
        in_a      = 13'sd0;
        in_b      = 13'sd0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst res_valid", res_valid, 0);
        check_eq("rst res_data", res_data, 0);
        check_eq("rst conv_sel", conv_sel, 0);
        check_eq("rst conv_a", conv_a, 0);
        check_eq("rst wb2", wb2, 0);
        check_eq("rst in_ready", in_ready, 1);

        // Basic window: 5 + 40 + 97 + 176 = 318.
        load_w('{1, 2, 3, 4, -1, 0, 1, 2});
        check_eq("load wa3", wa3, 4);
        check_eq("load wb0", wb0, -1);
        run_window("basic", '{10, 20, 30, 40}, '{5, 6, 7, 8}, 1'b0, 0, 1'b1, 318);

        // Width extremes: 4 * 2 * 4095 * 127 = 4160520.
        load_w('{127, 127, 127, 127, 127, 127, 127, 127});
        run_window("wide", '{4095, 4095, 4095, 4095}, '{4095, 4095, 4095, 4095},
                   1'b0, 0, 1'b1, 4160520);

        // Backpressure: window 1 (318) pending, window 2 = 0 + 4 + 12 + 24 = 40.
        load_w('{1, 2, 3, 4, -1, 0, 1, 2});
        res_ready = 1'b0;
        run_window("bp w1", '{10, 20, 30, 40}, '{5, 6, 7, 8}, 1'b0, 0, 1'b1, 318);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 13'(i + 1);
            in_b     = 13'(i + 1);
            check_eq("bp tap in_ready", in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check_eq("bp tap conv_sel", conv_sel, i);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 13'sd4;
        in_b     = 13'sd4;
        check_eq("bp stall in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("bp hold in_ready", in_ready, 0);
        check_eq("bp hold conv_sel", conv_sel, 2);
        check_eq("bp hold res_valid", res_valid, 1);
        check_eq("bp hold res_data", res_data, 318);
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        check_eq("bp release in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("bp tap3 conv_sel", conv_sel, 3);
        check_eq("bp consumed res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        check_eq("bp w2 res_valid", res_valid, 1);
        check_eq("bp w2 res_data", res_data, 40);
        @(posedge clk);
        #1;
        check_eq("bp w2 clear", res_valid, 0);

        // ReLU: negated weights give -318, clamped to 0 when enabled.
        load_w('{-1, -2, -3, -4, 1, 0, -1, -2});
`ifdef CONV_RELU_EN
        run_window("relu", '{10, 20, 30, 40}, '{5, 6, 7, 8}, 1'b0, 0, 1'b1, 0);
`else
        run_window("relu", '{10, 20, 30, 40}, '{5, 6, 7, 8}, 1'b0, 0, 1'b1, -318);
`endif

        // Mid-window reset with a pending result, then two taps of a new window.
        load_w('{1, 2, 3, 4, -1, 0, 1, 2});
        res_ready = 1'b0;
        run_window("pre rst", '{10, 20, 30, 40}, '{5, 6, 7, 8}, 1'b0, 0, 1'b1, 318);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 13'sd9;
            in_b     = 13'sd9;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        res_ready = 1'b1;
        check_eq("mid rst res_valid", res_valid, 0);
        check_eq("mid rst res_data", res_data, 0);
        check_eq("mid rst conv_sel", conv_sel, 0);
        check_eq("mid rst wa0", wa0, 0);
        check_eq("mid rst wb3", wb3, 0);
        check_eq("mid rst in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid rst no result", res_valid, 0);

        // WA0 written alongside the tap-0 accept: 10 * 5 = 50, other weights zero.
        run_window("wr tap0", '{10, 20, 30, 40}, '{5, 6, 7, 8}, 1'b1, 5, 1'b1, 50);
        check_eq("wr tap0 wa0", wa0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
